// File: rtl/adat_rx_scheduler_if.sv
// Mixer-side stream bus of the ADAT receive scheduler: one signed 24-bit sample per beat,
// tagged with its global channel index and an end-of-frame marker.
interface adat_rx_scheduler_if #(
    parameter int NUM_PORTS = 2
);
    localparam int CHW = $clog2(NUM_PORTS * 8);

    // A word moves when out_valid and out_ready are both high on a rising clk edge; once
    // out_valid is raised, out_data/out_chan/out_last stay stable until that transfer happens.
    logic           out_valid;
    logic           out_ready;
    logic [23:0]    out_data;
    logic [CHW-1:0] out_chan;
    logic           out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_chan,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_chan,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/adat_rx_scheduler.sv
// Captures decoded ADAT frames per port, tracks lock, and streams a snapshot of every channel per sample_tick.
// Optional feature macro: ADAT_USER_BITS_EN adds per-port user bits (rx_user in, user_bits out).
module adat_rx_scheduler #(
    parameter int NUM_PORTS      = 2,
    parameter int LOCK_FRAMES    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PORTS-1:0]     rx_ready,
    input  logic [NUM_PORTS-1:0]     rx_valid,
    input  logic [NUM_PORTS*192-1:0] rx_audio,
`ifdef ADAT_USER_BITS_EN
    input  logic [NUM_PORTS*3-1:0]   rx_user,
    output logic [NUM_PORTS*3-1:0]   user_bits,
`endif
    input  logic                     sample_tick,
    adat_rx_scheduler_if.master      bus,
    output logic [NUM_PORTS-1:0]     locked,
    output logic                     overrun,
    output logic [NUM_PORTS-1:0]     underrun,
    output logic                     o_dbg_state
);
    localparam int NCH = NUM_PORTS * 8;
    localparam int CHW = $clog2(NCH);
    localparam int GW  = $clog2(LOCK_FRAMES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CHW-1:0] LAST_IDX = CHW'(NCH - 1);
    localparam logic [GW-1:0]  GOOD_MAX = GW'(LOCK_FRAMES);
    localparam logic [TW-1:0]  TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CHW-1:0]       r_idx;
    logic [NUM_PORTS-1:0] r_rx_ready_q;
    logic [NUM_PORTS-1:0] r_fresh;
    logic [NUM_PORTS-1:0] r_locked;
    logic [NUM_PORTS-1:0] r_underrun;
    logic                 r_overrun;
    logic [GW-1:0]        r_good_cnt [NUM_PORTS];
    logic [TW-1:0]        r_to_cnt   [NUM_PORTS];
    logic [23:0]          r_cap      [NCH];
    logic [23:0]          r_shadow   [NCH];
    logic [NUM_PORTS-1:0] w_edge;
    logic [NUM_PORTS-1:0] w_timeout;
    logic                 w_snap;
    logic                 w_out_valid;
    logic                 w_xfer;
`ifdef ADAT_USER_BITS_EN
    logic [NUM_PORTS*3-1:0] r_cap_user;
    logic [NUM_PORTS*3-1:0] r_user_bits;
    assign user_bits = r_user_bits;
`endif

    assign w_edge = rx_ready & ~r_rx_ready_q;
    assign w_snap = (r_state == S_IDLE) && sample_tick;

    always_comb begin
        w_timeout = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_timeout[p] = (r_to_cnt[p] == TO_MAX);
        end
    end

    // Per-port capture, lock qualification and frame timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_ready_q <= '0;
            r_fresh      <= '0;
            r_locked     <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_good_cnt[p] <= '0;
                r_to_cnt[p]   <= '0;
            end
            for (int i = 0; i < NCH; i++) begin
                r_cap[i] <= '0;
            end
`ifdef ADAT_USER_BITS_EN
            r_cap_user <= '0;
`endif
        end else begin
            r_rx_ready_q <= rx_ready;
            for (int p = 0; p < NUM_PORTS; p++) begin
                // A frame arriving with the snapshot overrides this clear and stays fresh for the next tick.
                if (w_snap) begin
                    r_fresh[p] <= 1'b0;
                end
                if (w_edge[p]) begin
                    r_to_cnt[p] <= '0;
                    if (rx_valid[p]) begin
                        for (int c = 0; c < 8; c++) begin
                            r_cap[p*8+c] <= rx_audio[(p*8+c)*24 +: 24];
                        end
`ifdef ADAT_USER_BITS_EN
                        r_cap_user[p*3 +: 3] <= rx_user[p*3 +: 3];
`endif
                        r_fresh[p] <= 1'b1;
                        if (r_good_cnt[p] != GOOD_MAX) begin
                            r_good_cnt[p] <= r_good_cnt[p] + GW'(1);
                        end else begin
                            r_locked[p] <= 1'b1;
                        end
                    end else begin
                        for (int c = 0; c < 8; c++) begin
                            r_cap[p*8+c] <= '0;
                        end
`ifdef ADAT_USER_BITS_EN
                        r_cap_user[p*3 +: 3] <= '0;
`endif
                        r_fresh[p]    <= 1'b0;
                        r_good_cnt[p] <= '0;
                        r_locked[p]   <= 1'b0;
                    end
                end else if (w_timeout[p]) begin
                    for (int c = 0; c < 8; c++) begin
                        r_cap[p*8+c] <= '0;
                    end
`ifdef ADAT_USER_BITS_EN
                    r_cap_user[p*3 +: 3] <= '0;
`endif
                    r_good_cnt[p] <= '0;
                    r_locked[p]   <= 1'b0;
                end else begin
                    r_to_cnt[p] <= r_to_cnt[p] + TW'(1);
                    if (r_good_cnt[p] == GOOD_MAX) begin
                        r_locked[p] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sample_tick) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                w_out_valid = !rst;
                w_xfer      = w_out_valid && bus.out_ready;
                if (w_xfer && (r_idx == LAST_IDX)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Snapshot into shadow buffers, stream index and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_shadow[i] <= '0;
            end
`ifdef ADAT_USER_BITS_EN
            r_user_bits <= '0;
`endif
        end else begin
            r_overrun  <= (r_state == S_STREAM) && sample_tick;
            r_underrun <= '0;
            if (w_snap) begin
                r_idx <= '0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    r_underrun[p] <= r_locked[p] && !r_fresh[p];
                    if (!r_locked[p]) begin
                        for (int c = 0; c < 8; c++) begin
                            r_shadow[p*8+c] <= '0;
                        end
`ifdef ADAT_USER_BITS_EN
                        r_user_bits[p*3 +: 3] <= '0;
`endif
                    end else if (r_fresh[p]) begin
                        for (int c = 0; c < 8; c++) begin
                            r_shadow[p*8+c] <= r_cap[p*8+c];
                        end
`ifdef ADAT_USER_BITS_EN
                        r_user_bits[p*3 +: 3] <= r_cap_user[p*3 +: 3];
`endif
                    end
                end
            end else if (w_xfer) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + CHW'(1);
            end
        end
    end

    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? r_shadow[r_idx] : 24'd0;
    assign bus.out_chan  = w_out_valid ? r_idx : '0;
    assign bus.out_last  = w_out_valid && (r_idx == LAST_IDX);
    assign locked        = r_locked;
    assign overrun       = r_overrun;
    assign underrun      = r_underrun;
    assign o_dbg_state   = r_state;
endmodule
